// File: rtl/heavyhash_matrix_gen.sv
// Expands a 256-bit seed into the 64x64 4-bit heavyhash matrix with xoshiro256++,
// streaming 256 packed 64-bit words into the M_fifo under m_full backpressure.
module heavyhash_matrix_gen #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned CNT_W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] seed,
  input  logic         seed_valid,
  output logic         seed_ready,
  input  logic         abort,
  input  logic         m_full,
  output logic         m_we,
  output logic [63:0]  m_wdata,
  output logic         busy,
  output logic         done,
  output logic         seed_err
);

  typedef enum logic [1:0] {IDLE, GEN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [63:0]        s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               seed_ready_q, seed_ready_d;
  logic               m_we_q, m_we_d;
  logic [63:0]        m_wdata_q, m_wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               seed_err_q, seed_err_d;

  logic [63:0]        out_word;
  logic [63:0]        t, x2, x3, n0, n1, n2, n3;

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
    return (x << n) | (x >> (64 - n));
  endfunction

  // One full xoshiro256++ step; x2/x3 are the intermediate values of the in-place update.
  always_comb begin
    out_word = rotl64(s0_q + s3_q, 23) + s0_q;
    t  = s1_q << 17;
    x2 = s2_q ^ s0_q;
    x3 = s3_q ^ s1_q;
    n1 = s1_q ^ x2;
    n0 = s0_q ^ x3;
    n2 = x2 ^ t;
    n3 = rotl64(x3, 45);
  end

  always_comb begin
    state_d    = state_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    s3_d       = s3_q;
    cnt_d      = cnt_q;
    m_we_d     = 1'b0;
    m_wdata_d  = m_wdata_q;
    done_d     = 1'b0;
    seed_err_d = seed_err_q;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (seed_valid) begin
            s0_d       = seed[63:0];
            s1_d       = seed[127:64];
            s2_d       = seed[191:128];
            s3_d       = seed[255:192];
            cnt_d      = '0;
            seed_err_d = 1'b0;
            if (seed == '0) begin
              seed_err_d = 1'b1;
              done_d     = 1'b1;
            end else begin
              state_d = GEN;
            end
          end
        end
        GEN: begin
          if (!m_full) begin
            m_we_d    = 1'b1;
            m_wdata_d = out_word;
            s0_d      = n0;
            s1_d      = n1;
            s2_d      = n2;
            s3_d      = n3;
            if (cnt_q == CNT_W'(WORDS - 1)) begin
              state_d = FINISH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        FINISH: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // Handshake/status flags are registered from the next state so they line up with it.
    busy_d       = (state_d != IDLE);
    seed_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s0_q         <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      cnt_q        <= '0;
      seed_ready_q <= 1'b1;
      m_we_q       <= 1'b0;
      m_wdata_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      seed_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      cnt_q        <= cnt_d;
      seed_ready_q <= seed_ready_d;
      m_we_q       <= m_we_d;
      m_wdata_q    <= m_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      seed_err_q   <= seed_err_d;
    end
  end

  assign seed_ready = seed_ready_q;
  assign m_we       = m_we_q;
  assign m_wdata    = m_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign seed_err   = seed_err_q;

endmodule

// File: tb/tb_heavyhash_matrix_gen.sv
// Self-checking bench for heavyhash_matrix_gen against a queue-based xoshiro256++ reference.
module tb_heavyhash_matrix_gen;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] seed = '0;
  logic         seed_valid = 1'b0;
  logic         seed_ready;
  logic         abort = 1'b0;
  logic         m_full = 1'b0;
  logic         m_we;
  logic [63:0]  m_wdata;
  logic         busy;
  logic         done;
  logic         seed_err;

  int checks = 0;
  int errors = 0;

  logic [63:0] got[$];
  logic [63:0] exp_q[$];
  int done_cnt, viol, first_we, last_we, done_at;

  heavyhash_matrix_gen #(.WORDS(256), .CNT_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .seed(seed), .seed_valid(seed_valid),
    .seed_ready(seed_ready), .abort(abort), .m_full(m_full), .m_we(m_we),
    .m_wdata(m_wdata), .busy(busy), .done(done), .seed_err(seed_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned n);
    return (x << n) | (x >> (64 - n));
  endfunction

  task automatic model(input logic [255:0] sd);
    logic [63:0] s[4];
    logic [63:0] tmp;
    exp_q.delete();
    for (int k = 0; k < 4; k++) s[k] = sd[64*k +: 64];
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(rotl(s[0] + s[3], 23) + s[0]);
      tmp  = s[1] << 17;
      s[2] = s[2] ^ s[0];
      s[3] = s[3] ^ s[1];
      s[1] = s[1] ^ s[2];
      s[0] = s[0] ^ s[3];
      s[2] = s[2] ^ tmp;
      s[3] = rotl(s[3], 45);
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare collected words to the model; reports the first differing index (-1 = all match).
  task automatic check_words(input string tag);
    int bad;
    bad = -1;
    if (got.size() != exp_q.size()) bad = got.size();
    else for (int i = 0; i < got.size(); i++) if (bad < 0 && got[i] !== exp_q[i]) bad = i;
    check({tag, "_first_bad_idx"}, 64'(bad), 64'(-1));
    check({tag, "_word_count"}, 64'(got.size()), 64'd256);
  endtask

  // Offers sd for one cycle (or holds it if hold=1) and collects until done or budget.
  // mode: 0 no backpressure, 1 m_full 3 high/2 low, 2 random m_full.
  task automatic run_seed(input logic [255:0] sd, input int mode, input bit hold, input int budget);
    int n;
    logic fe;
    got.delete();
    done_cnt = 0; viol = 0; first_we = -1; last_we = -1; done_at = -1;
    n = 0;
    seed = sd;
    seed_valid = 1'b1;
    while (n < budget && done_cnt == 0) begin
      case (mode)
        1: m_full = ((n % 5) < 3);
        2: m_full = 1'($urandom_range(0, 1));
        default: m_full = 1'b0;
      endcase
      fe = m_full;
      step();
      n++;
      if (!hold) seed_valid = 1'b0;
      if (m_we) begin
        got.push_back(m_wdata);
        if (first_we < 0) first_we = n;
        last_we = n;
        if (fe) viol++;
      end
      if (done) begin
        done_cnt++;
        done_at = n;
      end
    end
    m_full = 1'b0;
  endtask

  logic [255:0] s1234, rseed, rseed2;

  initial begin
    s1234 = {64'd4, 64'd3, 64'd2, 64'd1};
    for (int k = 0; k < 8; k++) begin
      rseed[32*k +: 32]  = $urandom;
      rseed2[32*k +: 32] = $urandom;
    end
    rseed[0]  = 1'b1;
    rseed2[0] = 1'b1;

    // Reset values while held in reset
    #17;
    check("rst_seed_ready", 64'(seed_ready), 64'd1);
    check("rst_m_we", 64'(m_we), 64'd0);
    check("rst_m_wdata", m_wdata, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_seed_err", 64'(seed_err), 64'd0);
    rst_n = 1'b1;
    step();

    // Unthrottled reference run with the known seed
    model(s1234);
    run_seed(s1234, 0, 1'b0, 400);
    check("r1_word0", got.size() > 0 ? got[0] : 64'hx, 64'h0000_0000_0280_0001);
    check("r1_word1", got.size() > 1 ? got[1] : 64'hx, 64'h0000_0000_0380_0067);
    check_words("r1");
    check("r1_first_we_cycle", 64'(first_we), 64'd2);
    check("r1_last_we_cycle", 64'(last_we), 64'd257);
    check("r1_done_cycle", 64'(done_at), 64'd258);
    check("r1_done_count", 64'(done_cnt), 64'd1);
    step();
    check("r1_done_one_cycle", 64'(done), 64'd0);
    check("r1_seed_ready_after", 64'(seed_ready), 64'd1);
    check("r1_busy_after", 64'(busy), 64'd0);

    // Same seed under 3-high/2-low backpressure
    run_seed(s1234, 1, 1'b0, 2000);
    check_words("r2");
    check("r2_we_while_full", 64'(viol), 64'd0);
    check("r2_done_count", 64'(done_cnt), 64'd1);

    // Random seed under random backpressure
    model(rseed);
    run_seed(rseed, 2, 1'b0, 2000);
    check_words("r3");
    check("r3_we_while_full", 64'(viol), 64'd0);

    // All-zero seed
    run_seed('0, 0, 1'b0, 50);
    check("z_seed_err", 64'(seed_err), 64'd1);
    check("z_done_cycle", 64'(done_at), 64'd1);
    check("z_no_writes", 64'(got.size()), 64'd0);
    check("z_seed_ready", 64'(seed_ready), 64'd1);
    check("z_busy", 64'(busy), 64'd0);
    step();
    check("z_done_one_cycle", 64'(done), 64'd0);
    check("z_seed_err_sticky", 64'(seed_err), 64'd1);
    seed = rseed2;
    seed_valid = 1'b1;
    step();
    seed_valid = 1'b0;
    check("z_seed_err_cleared", 64'(seed_err), 64'd0);
    check("z_busy_after_nonzero", 64'(busy), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("z_abort_idle", 64'(seed_ready), 64'd1);

    // Abort after 100 words
    run_seed(s1234, 0, 1'b0, 101);
    check("ab_words_before", 64'(got.size()), 64'd100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_m_we_next", 64'(m_we), 64'd0);
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_seed_ready", 64'(seed_ready), 64'd1);
    begin
      int extra_we, extra_done;
      extra_we = 0; extra_done = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (m_we) extra_we++;
        if (done) extra_done++;
      end
      check("ab_no_more_we", 64'(extra_we), 64'd0);
      check("ab_no_done", 64'(extra_done), 64'd0);
    end
    model(s1234);
    run_seed(s1234, 0, 1'b0, 400);
    check("ab_restart_word0", got.size() > 0 ? got[0] : 64'hx, 64'h0000_0000_0280_0001);
    check_words("ab_restart");

    // Abort together with seed_valid in IDLE: seed not taken
    seed = rseed;
    seed_valid = 1'b1;
    abort = 1'b1;
    step();
    seed_valid = 1'b0;
    abort = 1'b0;
    check("ab_idle_busy", 64'(busy), 64'd0);
    step();
    check("ab_idle_no_we", 64'(m_we), 64'd0);

    // Asynchronous reset mid-generation
    run_seed(rseed, 0, 1'b0, 20);
    check("rs_busy_before", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_m_we_immediate", 64'(m_we), 64'd0);
    check("rs_busy_immediate", 64'(busy), 64'd0);
    check("rs_m_wdata_immediate", m_wdata, 64'd0);
    #3;
    rst_n = 1'b1;
    step();
    check("rs_seed_ready", 64'(seed_ready), 64'd1);
    check("rs_busy_after", 64'(busy), 64'd0);
    step();
    check("rs_idle_no_we", 64'(m_we), 64'd0);

    // seed_valid held through a whole run
    model(s1234);
    run_seed(s1234, 0, 1'b1, 400);
    check_words("hv");
    check("hv_done_cycle", 64'(done_at), 64'd258);
    check("hv_seed_ready_at_done", 64'(seed_ready), 64'd1);
    model(rseed2);
    seed = rseed2;
    step();
    check("hv_reaccept_busy", 64'(busy), 64'd1);
    check("hv_reaccept_ready", 64'(seed_ready), 64'd0);
    seed_valid = 1'b0;
    step();
    check("hv_new_word0_we", 64'(m_we), 64'd1);
    check("hv_new_word0", m_wdata, exp_q[0]);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
